// File: rtl/reg_file_32x32.sv
// Architectural register file: two combinational read ports with optional
// same-cycle write forwarding, one synchronous write port, and an unforwarded debug port.
module reg_file_32x32 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Entry 0 has no storage; reads of address 0 are forced to zero below.
  logic [WIDTH-1:0] mem [1:DEPTH-1];
  logic             wr_live;
  logic             fwd_en;

  assign wr_live = wr_en && (wr_addr != '0);
  assign fwd_en  = (BYPASS != 0) && rst_n && wr_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    dbg_data = '0;
    if (rd_addr1 != '0) begin
      rd_data1 = (fwd_en && (wr_addr == rd_addr1)) ? wr_data : mem[rd_addr1];
    end
    if (rd_addr2 != '0) begin
      rd_data2 = (fwd_en && (wr_addr == rd_addr2)) ? wr_data : mem[rd_addr2];
    end
    if (dbg_addr != '0) begin
      dbg_data = mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench: one BYPASS=1 and one BYPASS=0 register file share all stimulus;
// the stimulus process queues expected outputs and a monitor compares them on each sample strobe.
module tb_reg_file_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  a1, a2, wa, da;
  logic [31:0] wd;
  logic        we;
  logic [31:0] b_r1, b_r2, b_d, n_r1, n_r2, n_d;

  typedef struct {
    string       name;
    logic [31:0] b1, b2, bd, n1, n2, nd;
  } exp_t;

  exp_t        q[$];
  event        smp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  reg_file_32x32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr1(a1), .rd_addr2(a2), .rd_data1(b_r1), .rd_data2(b_r2),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .dbg_addr(da), .dbg_data(b_d)
  );

  reg_file_32x32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_addr1(a1), .rd_addr2(a2), .rd_data1(n_r1), .rd_data2(n_r2),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .dbg_addr(da), .dbg_data(n_d)
  );

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(smp);
      while (q.size() > 0) begin
        exp_t        e;
        logic [31:0] act [6];
        logic [31:0] exv [6];
        e   = q.pop_front();
        act = '{b_r1, b_r2, b_d, n_r1, n_r2, n_d};
        exv = '{e.b1, e.b2, e.bd, e.n1, e.n2, e.nd};
        for (int i = 0; i < 6; i++) begin
          checks++;
          if (act[i] !== exv[i]) begin
            errors++;
            $display("FAIL %s out%0d got %h expected %h", e.name, i, act[i], exv[i]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic push(input string n, input logic [31:0] b1, b2, bd, n1, n2, nd);
    exp_t e;
    e.name = n; e.b1 = b1; e.b2 = b2; e.bd = bd; e.n1 = n1; e.n2 = n2; e.nd = nd;
    q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> smp;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    if (a != 5'd0) mdl[a] = d;
    #1;
    we = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && rst_n && we && (wa == a)) return wd;
    return mdl[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0; da = '0;

    // Reset state
    a1 = 5'd5; a2 = 5'd31; da = 5'd17;
    push("reset", 0, 0, 0, 0, 0, 0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset between edges clears a written register
    wr(5'd5, 32'hDEADBEEF);
    a1 = 5'd5; a2 = 5'd5; da = 5'd5;
    push("pre_rst", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    sample();
    @(negedge clk);
    #1 rst_n = 1'b0;
    push("in_rst", 0, 0, 0, 0, 0, 0);
    sample();
    rst_n = 1'b1;
    push("post_rst", 0, 0, 0, 0, 0, 0);
    sample();
    mdl[5] = 32'h0;

    // Basic write/read
    wr(5'd7, 32'h12345678);
    wr(5'd31, 32'hA5A5A5A5);
    a1 = 5'd7; a2 = 5'd31; da = 5'd31;
    push("basic", 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5);
    sample();

    // r0 hard-wired
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; a1 = 5'd0; a2 = 5'd0; da = 5'd0;
    push("r0_pre", 0, 0, 0, 0, 0, 0);
    sample();
    @(posedge clk);
    #1;
    push("r0_post", 0, 0, 0, 0, 0, 0);
    sample();
    we = 1'b0;
    wr(5'd1, 32'h00000001);
    a1 = 5'd1; a2 = 5'd0; da = 5'd1;
    push("r1_r0", 32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1);
    sample();

    // Same-cycle write/read of r3
    wr(5'd3, 32'h00000001);
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'h2; a1 = 5'd3; a2 = 5'd3; da = 5'd3;
    push("byp_pre", 32'h2, 32'h2, 32'h1, 32'h1, 32'h1, 32'h1);
    sample();
    @(posedge clk);
    #1;
    mdl[3] = 32'h2;
    push("byp_post", 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2);
    sample();
    we = 1'b0;

    // wr_en gating
    @(negedge clk);
    we = 1'b0; wa = 5'd9; wd = 32'hCAFE0000; a1 = 5'd9; a2 = 5'd9; da = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    push("wen_gate", 0, 0, 0, 0, 0, 0);
    sample();

    // Write presented during reset is discarded and not forwarded
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'hBEEF0009;
    push("rst_wr_in", 0, 0, 0, 0, 0, 0);
    sample();
    @(posedge clk);
    #1;
    push("rst_wr_edge", 0, 0, 0, 0, 0, 0);
    sample();
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    push("rst_wr_post", 0, 0, 0, 0, 0, 0);
    sample();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Random sweep against the reference model
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      we = ($urandom_range(3) != 0);
      wa = 5'($urandom_range(31));
      wd = $urandom;
      a1 = 5'($urandom_range(31));
      a2 = 5'($urandom_range(31));
      da = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) a1 = wa;
      if ($urandom_range(3) == 0) a2 = wa;
      push("rand", mread(a1, 1'b1), mread(a2, 1'b1), mread(da, 1'b0),
           mread(a1, 1'b0), mread(a2, 1'b0), mread(da, 1'b0));
      sample();
      @(posedge clk);
      if (we && wa != 5'd0) mdl[wa] = wd;
    end

    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Architectural register file for the single-cycle 32-bit datapath: two combinational read ports feed the ALU operand muxes and the 32-bit AND/OR/adder units, and one synchronous write port takes the write-back result. Register 0 is hard-wired to zero. An optional same-cycle write-to-read bypass lets a value being written this cycle appear on the read ports immediately. A third read-only debug port supports bench inspection.

## Interface
- `WIDTH`, default 32: data width of every register and data port.
- `ADDR_W`, default 5: address width; depth is 2^ADDR_W registers.
- `BYPASS`, default 1: 1 enables write-to-read forwarding in the same cycle; 0 disables it.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rd_addr1`, input, ADDR_W: read port 1 address (rs).
- `rd_addr2`, input, ADDR_W: read port 2 address (rt).
- `rd_data1`, output, WIDTH: read port 1 data, combinational.
- `rd_data2`, output, WIDTH: read port 2 data, combinational.
- `wr_en`, input, 1: write enable.
- `wr_addr`, input, ADDR_W: write address (rd).
- `wr_data`, input, WIDTH: write data.
- `dbg_addr`, input, ADDR_W: debug read address.
- `dbg_data`, output, WIDTH: debug read data, combinational, never bypassed.

## Operation
- **Storage:** 2^ADDR_W registers of WIDTH bits. Entry 0 is not stored and always reads 0.
- **Write:** on a rising `clk` with `rst_n`=1, `wr_en`=1 and `wr_addr`≠0, `wr_data` is stored at `wr_addr`.
  - A write to address 0 is silently dropped.
  - `wr_en`=0 leaves all state unchanged.
- **Read, ports 1/2 (combinational):**
  - `rd_addrN`=0 gives 0.
  - Otherwise, if `BYPASS`=1, `rst_n`=1, `wr_en`=1 and `wr_addr`=`rd_addrN`, the port gives `wr_data`.
  - Otherwise the port gives the stored register.
- **Both read ports on one address:** they return identical data, including the bypassed case.
- **Debug port:** returns the stored value only. `dbg_addr`=0 gives 0. No forwarding.
- **Reset:**
  - `rst_n` low clears all registers to 0 immediately, independent of `clk`.
  - All three read ports then return 0 and bypass is suppressed.
  - Writes presented while `rst_n` is low are discarded.
- **Reset deasserted mid-cycle:** the first write that can take effect is on the first rising edge with `rst_n`=1.

## Timing
- Read latency is 0 cycles (combinational from address, and from `wr_*` when bypassing).
- Write latency is 1 edge. With `BYPASS`=0, the new value is visible on the read ports after the edge that performs the write.
- **Reset values of outputs:** `rd_data1`, `rd_data2` and `dbg_data` are all 0 while `rst_n`=0 and after reset until the first write.
- **Write and read of one address in the same cycle:**
  - `BYPASS`=1: reads return the new data before and after the edge.
  - `BYPASS`=0: reads return the old data before the edge and the new data after it.
- **Back-to-back writes to one address:** the last write wins. Each edge commits exactly one write.
- There is no handshake, stall or back-pressure. Every write request with `wr_en`=1 and `rst_n`=1 completes on the next edge.

## Test plan
- **Reset:** pulse `rst_n` low between clock edges after writing 32'hDEADBEEF to r5. Required: r5, read on both ports and on `dbg_data`, returns 0 while `rst_n` is low and stays 0 after reset is released, with no clock edge needed.
- **Basic write/read:** write 32'h1234_5678 to r7 and 32'hA5A5_A5A5 to r31. Required: `rd_addr1`=7 gives 32'h12345678, `rd_addr2`=31 gives 32'hA5A5A5A5, and `dbg_addr`=31 gives 32'hA5A5A5A5.
- **r0 hard-wired:**
  - Write 32'hFFFF_FFFF to r0. Required: `rd_data1`, `rd_data2` and `dbg_data` at address 0 stay 0, before and after the edge, including with `BYPASS`=1.
  - Also write r1=32'h0000_0001. Required: r1 reads 32'h00000001 and r0 still reads 0.
- **Bypass:** r3 holds 32'h1, and in the same cycle `wr_en`=1, `wr_addr`=3, `wr_data`=32'h2, `rd_addr1`=`rd_addr2`=3.
  - `BYPASS`=1: both ports read 32'h2 before the edge, and `dbg_data` at address 3 reads 32'h1.
  - `BYPASS`=0: both ports read 32'h1 before the edge and 32'h2 after it.
- **wr_en gating and write during reset:**
  - With `wr_en`=0, `wr_addr`=9, `wr_data`=32'hCAFE_0000, clock 3 edges. Required: r9 reads 0.
  - With `rst_n`=0 and `wr_en`=1, present a write to r9. Required: r9 reads 0 after reset is released.
- **Random sweep:** 1000 cycles of random writes and reads against a reference model. Required: all reads match the model under the bypass rules above.
